// File: rtl/conv_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_tap_sequencer
// Purpose  : Read-side controller for the coefficient-memory convolution
//            multiplier. A start pulse sweeps the tap address 0..MULT_N-1,
//            one address per clkf cycle. The two products that come back
//            PIPE_LAT cycles later are accumulated into signed A/B sums. The
//            sums are then offered downstream with a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   CONV_SAT_EN : when defined, each accumulate clamps to the signed ACC_W
//                 range and sets a sticky sat_flag. When undefined, the
//                 accumulators wrap and sat_flag is constant 0.
// ----------------------------------------------------------------------------
// Ports:
//   clkf        in   processing clock
//   rst         in   synchronous active-high reset
//   start       in   begin a pass (sampled only in IDLE)
//   busy        out  high in every state except IDLE
//   ADDRB_RAMK  out  tap address to coefficient RAM / sample window
//   prod_a/b    in   signed 32-bit products from the multiplier stage
//   acc_a/b     out  signed ACC_W-bit accumulated sums
//   out_valid   out  sums valid, held until out_ready
//   out_ready   in   downstream accept
//   sat_flag    out  sticky saturation indicator for the current result
// ============================================================================
module conv_tap_sequencer #(
  parameter int MULT_N   = 25,
  parameter int NLOG     = $clog2(MULT_N),
  parameter int PIPE_LAT = 2,
  parameter int ACC_W    = 40
) (
  input  logic             clkf,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [NLOG-1:0]  ADDRB_RAMK,
  input  logic [31:0]      prod_a,
  input  logic [31:0]      prod_b,
  output logic [ACC_W-1:0] acc_a,
  output logic [ACC_W-1:0] acc_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_flag
);

  localparam logic [NLOG-1:0] C_LAST_ADDR = NLOG'(MULT_N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } t_state;

  t_state              r_state;
  t_state              w_next;
  logic [NLOG-1:0]     r_addr;
  logic [PIPE_LAT-1:0] r_vld;
  logic [ACC_W-1:0]    r_acc_a;
  logic [ACC_W-1:0]    r_acc_b;
  logic                r_sat;

  logic                w_issue;
  logic                w_start_pass;
  logic [PIPE_LAT-1:0] w_vld_shift;
  logic                w_acc_en;
  logic [ACC_W-1:0]    w_acc_a_nxt;
  logic [ACC_W-1:0]    w_acc_b_nxt;
  logic                w_ovf_a;
  logic                w_ovf_b;

  // One in-flight marker per issued address; the top bit lines up with the
  // cycle in which that address's product is present on prod_*.
  assign w_issue     = (r_state == S_ISSUE);
  assign w_vld_shift = (r_vld << 1) | PIPE_LAT'(w_issue);
  assign w_acc_en    = r_vld[PIPE_LAT-1];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clkf) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_start_pass = 1'b0;
    busy         = 1'b1;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next       = S_ISSUE;
          w_start_pass = 1'b1;
        end
      end
      S_ISSUE: begin
        if (r_addr == C_LAST_ADDR) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave once the last in-flight product is being consumed this edge.
        if (w_vld_shift == '0) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Accumulate arithmetic
  // --------------------------------------------------------------------------
`ifdef CONV_SAT_EN
  localparam logic [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_sum_a;
  logic [ACC_W:0] w_sum_b;

  // One guard bit: overflow shows up as disagreement between the top two bits,
  // and the guard bit alone gives the true sign for choosing the clamp rail.
  assign w_sum_a = {r_acc_a[ACC_W-1], r_acc_a} + {{(ACC_W-31){prod_a[31]}}, prod_a};
  assign w_sum_b = {r_acc_b[ACC_W-1], r_acc_b} + {{(ACC_W-31){prod_b[31]}}, prod_b};
  assign w_ovf_a = w_sum_a[ACC_W] ^ w_sum_a[ACC_W-1];
  assign w_ovf_b = w_sum_b[ACC_W] ^ w_sum_b[ACC_W-1];
  assign w_acc_a_nxt = w_ovf_a ? (w_sum_a[ACC_W] ? C_ACC_MIN : C_ACC_MAX) : w_sum_a[ACC_W-1:0];
  assign w_acc_b_nxt = w_ovf_b ? (w_sum_b[ACC_W] ? C_ACC_MIN : C_ACC_MAX) : w_sum_b[ACC_W-1:0];
`else
  assign w_acc_a_nxt = r_acc_a + {{(ACC_W-32){prod_a[31]}}, prod_a};
  assign w_acc_b_nxt = r_acc_b + {{(ACC_W-32){prod_b[31]}}, prod_b};
  assign w_ovf_a     = 1'b0;
  assign w_ovf_b     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Address, in-flight tracking and accumulators
  // --------------------------------------------------------------------------
  always_ff @(posedge clkf) begin
    if (rst) begin
      r_addr  <= '0;
      r_vld   <= '0;
      r_acc_a <= '0;
      r_acc_b <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_vld <= w_vld_shift;
      if (w_start_pass) begin
        r_addr  <= '0;
        r_acc_a <= '0;
        r_acc_b <= '0;
        r_sat   <= 1'b0;
      end else begin
        // Address returns to 0 after the last tap so it reads 0 outside ISSUE.
        if (w_issue) begin
          r_addr <= (r_addr == C_LAST_ADDR) ? '0 : r_addr + NLOG'(1);
        end
        if (w_acc_en) begin
          r_acc_a <= w_acc_a_nxt;
          r_acc_b <= w_acc_b_nxt;
          r_sat   <= r_sat | w_ovf_a | w_ovf_b;
        end
      end
    end
  end

  assign ADDRB_RAMK = r_addr;
  assign acc_a      = r_acc_a;
  assign acc_b      = r_acc_b;
  assign sat_flag   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_conv_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_tap_sequencer
// Purpose  : Directed self-checking bench for conv_tap_sequencer. A default
//            instance (ACC_W=40) and a narrow instance (ACC_W=36) share all
//            inputs; the narrow one is examined in the saturation scenario.
//            Expected saturation results follow CONV_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_tap_sequencer;

  localparam int MULT_N = 25;
  localparam int NLOG   = 5;

  logic        clkf = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] prod_a = '0;
  logic [31:0] prod_b = '0;

  logic            busy, out_valid, sat_flag;
  logic [NLOG-1:0] addr;
  logic [39:0]     acc_a, acc_b;

  logic            s_busy, s_out_valid, s_sat_flag;
  logic [NLOG-1:0] s_addr;
  logic [35:0]     s_acc_a, s_acc_b;

  int tests = 0;
  int fails = 0;

  conv_tap_sequencer #(.MULT_N(25), .PIPE_LAT(2), .ACC_W(40)) dut (
    .clkf(clkf), .rst(rst), .start(start), .busy(busy), .ADDRB_RAMK(addr),
    .prod_a(prod_a), .prod_b(prod_b), .acc_a(acc_a), .acc_b(acc_b),
    .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag)
  );

  conv_tap_sequencer #(.MULT_N(25), .PIPE_LAT(2), .ACC_W(36)) dut_s (
    .clkf(clkf), .rst(rst), .start(start), .busy(s_busy), .ADDRB_RAMK(s_addr),
    .prod_a(prod_a), .prod_b(prod_b), .acc_a(s_acc_a), .acc_b(s_acc_b),
    .out_valid(s_out_valid), .out_ready(out_ready), .sat_flag(s_sat_flag)
  );

  always #5 clkf = ~clkf;

  // Product pattern for pass cycle c (cycle 1 carries address 0).
  // Mode 1 models RAM + multiplier: tap k returns in cycle k+3, garbage otherwise.
  task automatic drive_prod(input int mode, input int c);
    case (mode)
      0: begin prod_a = 32'd1;          prod_b = 32'hFFFF_FFFF; end
      1: begin
        if (c >= 3 && c <= 27) begin
          prod_a = 32'(c - 2);
          prod_b = 32'(2 * (c - 3));
        end else begin
          prod_a = $urandom;
          prod_b = $urandom;
        end
      end
      2: begin prod_a = 32'h7FFF_FFFF; prod_b = 32'd0; end
      default: begin prod_a = 32'd1; prod_b = 32'd1; end
    endcase
  endtask

  // Pulses start, then walks the pass cycle by cycle until out_valid.
  // Returns at the falling edge of the first valid cycle (or -1 on timeout),
  // with the number of cycles whose address or busy disagreed with the plan.
  task automatic do_pass(input int mode, output int valid_cyc, output int seq_err);
    int exp_addr;
    valid_cyc = -1;
    seq_err   = 0;
    start = 1'b1;
    drive_prod(mode, 0);
    @(posedge clkf); #1;
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      drive_prod(mode, c);
      @(negedge clkf);
      exp_addr = (c <= MULT_N) ? c - 1 : 0;
      if (addr !== NLOG'(exp_addr) || busy !== 1'b1) seq_err++;
      if (out_valid === 1'b1) begin
        valid_cyc = c;
        break;
      end
      @(posedge clkf); #1;
    end
  endtask

  // Accepts the result from the falling edge of a HOLD cycle.
  task automatic accept_result();
    out_ready = 1'b1;
    @(posedge clkf); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clkf);
    #1 rst = 1'b0;
    @(negedge clkf);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sat_flag !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: busy=%b valid=%b sat=%b, required 0 0 0", busy, out_valid, sat_flag);
    end
    tests++;
    if (addr !== '0) begin
      fails++;
      $display("FAIL reset_addr: got %0d, required 0", addr);
    end
    tests++;
    if (acc_a !== '0 || acc_b !== '0 || s_acc_a !== '0) begin
      fails++;
      $display("FAIL reset_acc: a=%0h b=%0h sa=%0h, required 0", acc_a, acc_b, s_acc_a);
    end
    @(posedge clkf); #1;
  endtask

  task automatic test_const_products();
    int vc, se;
    logic [39:0] e_b;
    e_b = 40'd0 - 40'd25;
    do_pass(0, vc, se);
    tests++;
    if (vc !== 28) begin
      fails++;
      $display("FAIL const_latency: out_valid first in cycle %0d, required 28", vc);
    end
    tests++;
    if (se !== 0) begin
      fails++;
      $display("FAIL const_addr_seq: %0d bad cycles, required 0", se);
    end
    tests++;
    if (acc_a !== 40'd25 || acc_b !== e_b) begin
      fails++;
      $display("FAIL const_sums: a=%0h b=%0h, required %0h %0h", acc_a, acc_b, 40'd25, e_b);
    end
    accept_result();
  endtask

  task automatic test_delay_model();
    int vc, se;
    do_pass(1, vc, se);
    tests++;
    if (vc !== 28 || se !== 0) begin
      fails++;
      $display("FAIL delay_timing: valid cycle %0d bad cycles %0d, required 28 0", vc, se);
    end
    tests++;
    if (acc_a !== 40'd325 || acc_b !== 40'd600) begin
      fails++;
      $display("FAIL delay_sums: a=%0d b=%0d, required 325 600", acc_a, acc_b);
    end
    // Left in HOLD for the held-handshake scenario.
  endtask

  task automatic test_held_handshake();
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clkf); #1;
      start  = (i == 3);
      prod_a = $urandom;
      prod_b = $urandom;
      @(negedge clkf);
      if (out_valid !== 1'b1 || busy !== 1'b1 || acc_a !== 40'd325 || acc_b !== 40'd600) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
    end
    // start coincides with the accepting edge and must be dropped.
    @(posedge clkf); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clkf); #1;
    start = 1'b0;
    out_ready = 1'b0;
    @(negedge clkf);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: busy=%b valid=%b, required 0 0", busy, out_valid);
    end
    tests++;
    if (acc_a !== 40'd325 || acc_b !== 40'd600) begin
      fails++;
      $display("FAIL hold_keep_sums: a=%0d b=%0d, required 325 600", acc_a, acc_b);
    end
    @(posedge clkf); #1;
    @(negedge clkf);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_start_queued: busy=%b, required 0", busy);
    end
    @(posedge clkf); #1;
  endtask

  task automatic test_reset_mid_pass();
    int vc, se;
    start = 1'b1;
    drive_prod(3, 0);
    @(posedge clkf); #1;
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clkf); #1;
    end
    rst = 1'b1;
    @(posedge clkf); #1;
    rst = 1'b0;
    @(negedge clkf);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || addr !== '0 || sat_flag !== 1'b0) begin
      fails++;
      $display("FAIL midrst_ctrl: busy=%b valid=%b addr=%0d sat=%b, required 0 0 0 0",
               busy, out_valid, addr, sat_flag);
    end
    tests++;
    if (acc_a !== '0 || acc_b !== '0) begin
      fails++;
      $display("FAIL midrst_acc: a=%0d b=%0d, required 0 0", acc_a, acc_b);
    end
    do_pass(3, vc, se);
    tests++;
    if (vc !== 28 || acc_a !== 40'd25 || acc_b !== 40'd25) begin
      fails++;
      $display("FAIL midrst_fresh: cycle %0d a=%0d b=%0d, required 28 25 25", vc, acc_a, acc_b);
    end
    accept_result();
  endtask

  task automatic test_saturation();
    int vc, se;
    logic [35:0] e_s;
    logic        e_sat;
`ifdef CONV_SAT_EN
    e_s   = 36'h7_FFFF_FFFF;
    e_sat = 1'b1;
`else
    e_s   = 36'd0 - 36'd15032385561;
    e_sat = 1'b0;
`endif
    do_pass(2, vc, se);
    tests++;
    if (s_acc_a !== e_s || s_sat_flag !== e_sat) begin
      fails++;
      $display("FAIL sat_narrow: acc=%0h sat=%b, required %0h %b", s_acc_a, s_sat_flag, e_s, e_sat);
    end
    tests++;
    if (acc_a !== 40'd53687091175 || sat_flag !== 1'b0 || s_acc_b !== '0) begin
      fails++;
      $display("FAIL sat_wide: acc=%0d sat=%b nb=%0d, required 53687091175 0 0", acc_a, sat_flag, s_acc_b);
    end
    accept_result();
  endtask

  task automatic test_back_to_back();
    int vc1, vc2, se1, se2;
    out_ready = 1'b1;
    do_pass(3, vc1, se1);
    @(posedge clkf); #1;
    @(negedge clkf);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: busy=%b in cycle 29, required 0", busy);
    end
    do_pass(3, vc2, se2);
    tests++;
    if (vc1 !== 28 || vc2 !== 28 || se1 !== 0 || se2 !== 0 || acc_a !== 40'd25) begin
      fails++;
      $display("FAIL b2b_passes: cycles %0d %0d bad %0d %0d acc=%0d, required 28 28 0 0 25",
               vc1, vc2, se1, se2, acc_a);
    end
    @(posedge clkf); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_const_products();
    test_delay_model();
    test_held_handshake();
    test_reset_mid_pass();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_tap_sequencer.md
# conv_tap_sequencer

Read-side controller for the coefficient-memory convolution multiplier. On a `start` pulse it sweeps the coefficient/sample read address over all `MULT_N` taps on `clkf`. It takes the two 32-bit products returned by the multiplier stage a fixed pipeline delay later and accumulates them into A/B correlation sums. It then presents the sums downstream with a valid/ready handshake. It sits between the D3 processing scheduler (which issues `start`) and the multiplier/coefficient-RAM block (which consumes `ADDRB_RAMK`).

## Interface
- `MULT_N`, 25, number of taps per pass.
- `NLOG`, `$clog2(MULT_N)`, address width.
- `PIPE_LAT`, 2, cycles from address out to product in (1 RAM read + 1 multiplier register).
- `ACC_W`, 40, accumulator width (signed), ≥ 33.

Ports:
- `clkf`  in  1  processing clock.
- `rst`  in  1  reset; synchronous, active-high, on `clkf`.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `ADDRB_RAMK`  out  NLOG  tap address to coefficient RAM and sample window.
- `prod_a`  in  32  product A, signed two's complement.
- `prod_b`  in  32  product B, signed two's complement.
- `acc_a`  out  ACC_W  accumulated sum A.
- `acc_b`  out  ACC_W  accumulated sum B.
- `out_valid`  out  1  sums valid; held until accepted.
- `out_ready`  in  1  downstream accepts when high with `out_valid`.
- `sat_flag`  out  1  sticky saturation indicator for the current result.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - `start`=1 → ISSUE.
  - On that transition: `ADDRB_RAMK`←0, `acc_a`/`acc_b`←0, `sat_flag`←0, tap counter←0.
- ISSUE:
  - One address per cycle: 0, 1, …, `MULT_N`-1.
  - The cycle after address `MULT_N`-1 is presented → DRAIN, with `ADDRB_RAMK`←0.
  - Addresses never exceed `MULT_N`-1. There is no wrap within a pass.
- In-flight tracking:
  - A `PIPE_LAT`-deep valid shift register records each ISSUE cycle.
  - When its output is 1, `prod_a`/`prod_b` are sign-extended to `ACC_W` and added to `acc_a`/`acc_b` at that edge.
  - When its output is 0, products are ignored.
- DRAIN: wait until the shift register is empty (`PIPE_LAT` cycles) → HOLD.
- HOLD:
  - `out_valid`=1. `acc_a`, `acc_b` and `sat_flag` are frozen.
  - `out_valid`&&`out_ready` at an edge → IDLE; `out_valid` drops next cycle.
- `start` outside IDLE is ignored and never queued.
  - This includes `start` in the same cycle as the HOLD handshake. The earliest new pass is `start` sampled in the following IDLE cycle.
- `ADDRB_RAMK` is 0 in every state except ISSUE.
- Accumulators keep their final value after the handshake until the next `start`.
- Reset mid-operation: at the `rst` edge, state→IDLE and the valid shift register is cleared. Products already in the multiplier pipe are discarded.
- Reset values: `busy`=0, `ADDRB_RAMK`=0, `acc_a`=0, `acc_b`=0, `out_valid`=0, `sat_flag`=0.

## Timing
- Edge 0 samples `start`. Address k is on `ADDRB_RAMK` during cycle k+1.
- Product for tap k is on `prod_*` during cycle k+1+`PIPE_LAT` and is accumulated at the end of that cycle.
- Last address: cycle `MULT_N`. Last accumulate: end of cycle `MULT_N`+`PIPE_LAT`.
- `out_valid` first high in cycle `MULT_N`+`PIPE_LAT`+1. For defaults: address 0 in cycle 1, address 24 in cycle 25, `out_valid` in cycle 28.
- `busy` is high from cycle 1 through the cycle in which the handshake occurs.
- Minimum start-to-start period: `MULT_N`+`PIPE_LAT`+2 cycles (29 for defaults) with `out_ready` tied high.

## Configuration
- `CONV_SAT_EN` defined:
  - Each accumulate clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Any clamp sets `sat_flag`, which stays set until the next `start` or `rst`.
- `CONV_SAT_EN` undefined:
  - Accumulation wraps modulo 2^ACC_W.
  - `sat_flag` is tied to 0.
- The port list is identical in both builds.

## Test plan
- **Constant products:** `prod_a`=1, `prod_b`=0xFFFFFFFF (−1) every cycle, defaults → `out_valid` first in cycle 28, `acc_a`=25, `acc_b`=−25, addresses 0..24 seen in cycles 1..25.
- **Delay-modelled multiplier:** bench returns `prod_a`=addr+1 and `prod_b`=2·addr, delayed 2 cycles → `acc_a`=325, `acc_b`=600. Garbage driven on `prod_*` outside accumulate slots does not change the result.
- **Held handshake:** `out_ready`=0 for 10 cycles after `out_valid`, with `start` pulsed during HOLD → `acc_*`, `out_valid` and `busy` are stable and `start` is ignored. Raise `out_ready` → IDLE next cycle, `busy`=0.
- **Reset mid-pass:** `rst` in cycle 12 of a pass → the next cycle has all outputs at reset values. A fresh `start` with products of 1 yields exactly `acc_a`=25.
- **Saturation:** `ACC_W`=36, `prod_a`=0x7FFFFFFF on all 25 taps:
  - With `CONV_SAT_EN`: `acc_a`=2^35−1, `sat_flag`=1.
  - Without: `acc_a`=−15032385561, `sat_flag`=0.
